// File: rtl/rupd_sequencer.sv
// rtl/rupd_sequencer.sv - remote-update user-port command sequencer (optional verify step: RUPD_SEQ_VERIFY_EN)
module rupd_sequencer #(
    parameter int TIMEOUT_CYC = 65535,
    parameter int SETTLE_CYC  = 8
) (
    input  logic        CLK,
    input  logic        RESETb,
    input  logic        START_RECFG,
    input  logic        START_READ,
    input  logic [6:0]  PGM,
    output logic [1:0]  M_ADDR,
    output logic [31:0] M_DATA_OUT,
    output logic        M_CEb,
    output logic        M_WEb,
    input  logic [31:0] M_DATA_IN,
    output logic        SEQ_BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [11:0] CUR_CFG
);

`ifdef RUPD_SEQ_VERIFY_EN
    localparam logic [2:0] RECFG_STEP = 3'd4;
`else
    localparam logic [2:0] RECFG_STEP = 3'd3;
`endif
    localparam logic [7:0]  CTRL_READ   = 8'h01;
    localparam logic [7:0]  CTRL_WRITE  = 8'h02;
    localparam logic [7:0]  CTRL_RECFG  = 8'h80;
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] POLL_LAST   = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_CTRL, SETTLE, POLL, NEXT, RECFG, DONE_ST
    } state_t;

    state_t      state;
    logic [2:0]  step;
    logic        rd_mode;
    logic [6:0]  pgm_q;
    logic [31:0] cnt;
    logic [39:0] cur_cmd;
    logic [39:0] start_cmd;
    logic        poll_ok;
    logic        unused_bits;

    // Command for a step: {control byte, data-register word}
    function automatic logic [39:0] cmd(input logic rd, input logic [2:0] s, input logic [6:0] pgm);
        logic [2:0]  param;
        logic [11:0] data;
        logic [7:0]  ctrl;
        param = 3'd5;
        data  = 12'h000;
        ctrl  = CTRL_READ;
        if (!rd) begin
            case (s)
                3'd0:    begin param = 3'd0; data = 12'h004;       ctrl = CTRL_WRITE; end
                3'd1:    begin param = 3'd4; data = {5'h0, pgm};   ctrl = CTRL_WRITE; end
                3'd2:    begin param = 3'd5; data = 12'h001;       ctrl = CTRL_WRITE; end
`ifdef RUPD_SEQ_VERIFY_EN
                3'd3:    begin param = 3'd4; data = 12'h000;       ctrl = CTRL_READ;  end
`endif
                default: begin param = 3'd5; data = 12'h001;       ctrl = CTRL_RECFG; end
            endcase
        end
        return {ctrl, 13'h0, param, 4'h0, data};
    endfunction

    // Current-step command and the command to launch on acceptance (RECFG wins over READ)
    always_comb begin
        cur_cmd   = cmd(rd_mode, step, pgm_q);
        start_cmd = cmd(!START_RECFG, 3'd0, PGM);
        poll_ok   = !M_DATA_IN[31] && (M_DATA_IN[23:16] == 8'h00);
    end

    assign unused_bits = ^{M_DATA_IN[30:24], M_DATA_IN[15:12], start_cmd[39:32]};

    // Sequencer FSM with registered bus and status outputs
    always_ff @(posedge CLK or negedge RESETb) begin
        if (!RESETb) begin
            state      <= IDLE;
            step       <= 3'd0;
            rd_mode    <= 1'b0;
            pgm_q      <= 7'h00;
            cnt        <= 32'd0;
            M_ADDR     <= 2'd0;
            M_DATA_OUT <= 32'h0;
            M_CEb      <= 1'b1;
            M_WEb      <= 1'b1;
            SEQ_BUSY   <= 1'b0;
            DONE       <= 1'b0;
            ERROR      <= 1'b0;
            CUR_CFG    <= 12'h000;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START_RECFG || START_READ) begin
                        rd_mode    <= !START_RECFG;
                        if (START_RECFG) pgm_q <= PGM;
                        step       <= 3'd0;
                        cnt        <= 32'd0;
                        ERROR      <= 1'b0;
                        SEQ_BUSY   <= 1'b1;
                        M_ADDR     <= 2'd0;
                        M_DATA_OUT <= start_cmd[31:0];
                        M_CEb      <= 1'b0;
                        M_WEb      <= 1'b0;
                        state      <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    M_ADDR     <= 2'd1;
                    M_DATA_OUT <= {24'h0, cur_cmd[39:32]};
                    state      <= WR_CTRL;
                end
                WR_CTRL: begin
                    M_CEb <= 1'b1;
                    M_WEb <= 1'b1;
                    cnt   <= 32'd0;
                    if (!rd_mode && step == RECFG_STEP) begin
                        // the device reconfigures; it will not answer a poll
                        DONE  <= 1'b1;
                        state <= RECFG;
                    end else begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= 32'd0;
                        state <= POLL;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                POLL: begin
                    if (poll_ok) begin
                        cnt <= 32'd0;
                        if (rd_mode) begin
                            CUR_CFG <= M_DATA_IN[11:0];
                            DONE    <= 1'b1;
                            state   <= DONE_ST;
                        end
`ifdef RUPD_SEQ_VERIFY_EN
                        else if (step == 3'd3 && M_DATA_IN[6:0] != pgm_q) begin
                            ERROR <= 1'b1;
                            state <= DONE_ST;
                        end
`endif
                        else begin
                            step  <= step + 3'd1;
                            state <= NEXT;
                        end
                    end else if (cnt == POLL_LAST) begin
                        ERROR <= 1'b1;
                        state <= DONE_ST;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                NEXT: begin
                    M_ADDR     <= 2'd0;
                    M_DATA_OUT <= cur_cmd[31:0];
                    M_CEb      <= 1'b0;
                    M_WEb      <= 1'b0;
                    state      <= WR_DATA;
                end
                RECFG: begin
                    SEQ_BUSY <= 1'b0;
                    state    <= IDLE;
                end
                DONE_ST: begin
                    SEQ_BUSY <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rupd_sequencer.sv
// tb/tb_rupd_sequencer.sv - directed table-driven bench for rupd_sequencer
module tb_rupd_sequencer;
    localparam int TMO    = 16;
    localparam int SETTLE = 4;
`ifdef RUPD_SEQ_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESETb = 1'b0;
    logic        START_RECFG = 1'b0;
    logic        START_READ = 1'b0;
    logic [6:0]  PGM = 7'h00;
    logic [1:0]  M_ADDR;
    logic [31:0] M_DATA_OUT;
    logic        M_CEb, M_WEb;
    logic [31:0] M_DATA_IN;
    logic        SEQ_BUSY, DONE, ERROR;
    logic [11:0] CUR_CFG;

    rupd_sequencer #(.TIMEOUT_CYC(TMO), .SETTLE_CYC(SETTLE)) dut (
        .CLK(CLK), .RESETb(RESETb), .START_RECFG(START_RECFG), .START_READ(START_READ),
        .PGM(PGM), .M_ADDR(M_ADDR), .M_DATA_OUT(M_DATA_OUT), .M_CEb(M_CEb), .M_WEb(M_WEb),
        .M_DATA_IN(M_DATA_IN), .SEQ_BUSY(SEQ_BUSY), .DONE(DONE), .ERROR(ERROR), .CUR_CFG(CUR_CFG)
    );

    always #5 CLK = ~CLK;

    int          errors = 0;
    int          checks = 0;
    logic [33:0] wlog[$];
    logic [33:0] exp_q[$];
    int          done_cnt = 0;
    int          busy_cnt = 0;
    logic [7:0]  pend = 8'h00;
    logic        stuck = 1'b0;
    logic [11:0] rd_data = 12'h000;

    // Status model: busy with the pending control byte for 3 cycles after a non-reconfigure control write
    assign M_DATA_IN = {(stuck || busy_cnt > 0), 7'h0, (busy_cnt > 0) ? pend : 8'h00, 4'h0, rd_data};

    // Bus monitor and status countdown
    always @(negedge CLK) begin
        if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
        if (!M_CEb && !M_WEb) begin
            wlog.push_back({M_ADDR, M_DATA_OUT});
            if (M_ADDR == 2'd1 && M_DATA_OUT[7:0] != 8'h80) begin
                busy_cnt = 3;
                pend     = M_DATA_OUT[7:0];
            end
        end
        if (DONE) done_cnt = done_cnt + 1;
    end

    typedef struct {
        bit          recfg;
        bit          read;
        logic [6:0]  pgm;
        logic [11:0] rd;
        bit          stk;
        bit          exp_err;
        int          exp_done;
        logic [11:0] exp_cfg;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Expected write sequence for a run
    task automatic make_exp(input bit recfg, input logic [6:0] pgm, input logic [11:0] rd, input bit stk);
        exp_q.delete();
        if (!recfg) begin
            push(2'd0, 32'h0005_0000); push(2'd1, 32'h01);
            return;
        end
        push(2'd0, 32'h0000_0004); push(2'd1, 32'h02);
        if (stk) return;
        push(2'd0, {13'h0, 3'd4, 4'h0, 5'h0, pgm}); push(2'd1, 32'h02);
        push(2'd0, 32'h0005_0001); push(2'd1, 32'h02);
        if (VER) begin
            push(2'd0, 32'h0004_0000); push(2'd1, 32'h01);
            if (rd[6:0] != pgm) return;
        end
        push(2'd0, 32'h0005_0001); push(2'd1, 32'h80);
    endtask

    task automatic cmp_writes(input string tag, input int base);
        chk({tag, " nwrites"}, 64'(wlog.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < wlog.size())
                chk($sformatf("%s w%0d", tag, i), 64'(wlog[base + i]), 64'(exp_q[i]));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (SEQ_BUSY && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, " finished"}, 64'(SEQ_BUSY), 64'd0);
        @(negedge CLK);
        #1;
    endtask

    task automatic pulse(input bit r, input bit d);
        START_RECFG = r;
        START_READ  = d;
        @(negedge CLK);
        START_RECFG = 1'b0;
        START_READ  = 1'b0;
    endtask

    initial begin
        int base;
        int dbase;
        int n;

        vecs[0] = '{1, 0, 7'h30, 12'h030, 0, 0,    1,    12'h000};
        vecs[1] = '{0, 1, 7'h00, 12'h001, 0, 0,    1,    12'h001};
        vecs[2] = '{0, 1, 7'h00, 12'hABC, 0, 0,    1,    12'hABC};
        vecs[3] = '{1, 0, 7'h7F, 12'h07F, 0, 0,    1,    12'hABC};
        vecs[4] = '{1, 0, 7'h30, 12'h031, 0, VER,  VER ? 0 : 1, 12'hABC};
        vecs[5] = '{1, 0, 7'h15, 12'h000, 1, 1,    0,    12'hABC};
        vecs[6] = '{0, 1, 7'h00, 12'h5A5, 0, 0,    1,    12'h5A5};
        vecs[7] = '{0, 1, 7'h00, 12'h111, 1, 1,    0,    12'h5A5};
        vecs[8] = '{1, 1, 7'h30, 12'h030, 0, 0,    1,    12'h5A5};

        // reset state
        @(negedge CLK);
        @(negedge CLK);
        chk("rst CEb", 64'(M_CEb), 64'd1);
        chk("rst WEb", 64'(M_WEb), 64'd1);
        chk("rst ADDR", 64'(M_ADDR), 64'd0);
        chk("rst DATA", 64'(M_DATA_OUT), 64'd0);
        chk("rst BUSY", 64'(SEQ_BUSY), 64'd0);
        chk("rst ERR", 64'(ERROR), 64'd0);
        chk("rst CFG", 64'(CUR_CFG), 64'd0);
        RESETb = 1'b1;
        @(negedge CLK);

        for (int v = 0; v < 9; v++) begin
            string tag;
            tag     = $sformatf("v%0d", v);
            stuck   = vecs[v].stk;
            rd_data = vecs[v].rd;
            PGM     = vecs[v].pgm;
            base    = wlog.size();
            dbase   = done_cnt;
            pulse(vecs[v].recfg, vecs[v].read);
            chk({tag, " busy"}, 64'(SEQ_BUSY), 64'd1);
            wait_idle(tag);
            make_exp(vecs[v].recfg, vecs[v].pgm, vecs[v].rd, vecs[v].stk);
            cmp_writes(tag, base);
            chk({tag, " error"}, 64'(ERROR), 64'(vecs[v].exp_err));
            chk({tag, " done"}, 64'(done_cnt - dbase), 64'(vecs[v].exp_done));
            chk({tag, " cfg"}, 64'(CUR_CFG), 64'(vecs[v].exp_cfg));
            stuck = 1'b0;
            repeat (2) @(negedge CLK);
        end

        // START_READ during recfg is ignored; PGM changes after acceptance do not matter
        rd_data = 12'h030;
        PGM     = 7'h30;
        base    = wlog.size();
        dbase   = done_cnt;
        pulse(1, 0);
        repeat (3) @(negedge CLK);
        PGM = 7'h11;
        pulse(0, 1);
        wait_idle("ign");
        repeat (20) @(negedge CLK);
        make_exp(1, 7'h30, 12'h030, 0);
        cmp_writes("ign", base);
        chk("ign done", 64'(done_cnt - dbase), 64'd1);
        chk("ign busy", 64'(SEQ_BUSY), 64'd0);
        chk("ign cfg", 64'(CUR_CFG), 64'h5A5);

        // reset asserted during step1 settle aborts immediately
        PGM  = 7'h30;
        base = wlog.size();
        pulse(1, 0);
        n = 0;
        while (wlog.size() - base < 4 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("rsq reached step1", 64'(wlog.size() - base), 64'd4);
        @(negedge CLK);
        #2;
        RESETb = 1'b0;
        #1;
        chk("rsq CEb", 64'(M_CEb), 64'd1);
        chk("rsq WEb", 64'(M_WEb), 64'd1);
        chk("rsq ADDR", 64'(M_ADDR), 64'd0);
        chk("rsq DATA", 64'(M_DATA_OUT), 64'd0);
        chk("rsq BUSY", 64'(SEQ_BUSY), 64'd0);
        chk("rsq DONE", 64'(DONE), 64'd0);
        chk("rsq CFG", 64'(CUR_CFG), 64'd0);
        repeat (3) @(negedge CLK);
        RESETb = 1'b1;
        repeat (40) @(negedge CLK);
        chk("rsq no more writes", 64'(wlog.size() - base), 64'd4);
        chk("rsq idle", 64'(SEQ_BUSY), 64'd0);
        chk("rsq err", 64'(ERROR), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rupd_sequencer.md
RUPD_SEQUENCER -- requirements
Module: rupd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 65535, poll-cycle limit per command before error.
REQ-002 SHALL have parameter SETTLE_CYC, default 8, CLK cycles waited after a control write before polling.
REQ-003 CLK  input  1  system clock.
REQ-004 RESETb  input  1  reset, asynchronous, active-low.
REQ-005 START_RECFG  input  1  pulse; start the full remote-reconfigure sequence.
REQ-006 START_READ  input  1  pulse; read the current-configuration parameter (param 5).
REQ-007 PGM  input  7  application image start page, giving start address {1'b0,PGM,16'h0}.
REQ-008 M_ADDR  output  2  register select toward the remote-update user port (0=data, 1=control).
REQ-009 M_DATA_OUT  output  32  write data toward the user port.
REQ-010 M_CEb, M_WEb  output  1 each  active-low chip enable and write strobe.
REQ-011 M_DATA_IN  input  32  status word: bit31 = busy, [23:16] = pending control byte, [11:0] = parameter data out.
REQ-012 SEQ_BUSY  output  1  high while any sequence runs.
REQ-013 DONE  output  1  one-cycle pulse on successful completion.
REQ-014 ERROR  output  1  sticky; set on timeout or verify mismatch; cleared by the next accepted START_*.
REQ-015 CUR_CFG  output  12  last parameter-5 readback value.

Function
REQ-016 Each user-port access SHALL be a single CLK cycle with M_CEb=0 and M_WEb=0; M_CEb and M_WEb SHALL be high otherwise.
REQ-017 Command issue SHALL follow this order:
- write addr 0 = {13'h0, param[2:0], 4'h0, data[11:0]};
- next cycle, write addr 1 with the control byte (0x01 read, 0x02 write, 0x80 reconfigure).
REQ-018 After a control write, the FSM SHALL count SETTLE_CYC cycles, then poll.
- Poll completes when M_DATA_IN[31]=0 and M_DATA_IN[23:16]=0 in the same cycle.
REQ-019 If poll does not complete within TIMEOUT_CYC cycles, the FSM SHALL set ERROR and go to IDLE without issuing further commands.
REQ-020 FSM states: IDLE, WR_DATA, WR_CTRL, SETTLE, POLL, NEXT, RECFG, DONE_ST; a step index (0..4) selects the current command.
REQ-021 The recfg sequence SHALL run these steps:
- step0: write param 0 = 12'h004;
- step1: write param 4 = {5'h0, PGM};
- step2: write param 5 = 12'h001;
- step3: reconfigure (0x80).
REQ-022 After the reconfigure control write, the FSM SHALL pulse DONE one cycle later, return to IDLE, and not poll.
REQ-023 The read sequence SHALL:
- issue read of param 5 (control 0x01), then poll;
- on completion, load CUR_CFG from M_DATA_IN[11:0] and pulse DONE.
REQ-024 PGM SHALL be sampled into an internal register when START_RECFG is accepted; later PGM changes SHALL have no effect on the running sequence.
REQ-025 START_* SHALL be accepted only in IDLE; pulses while SEQ_BUSY=1 SHALL be ignored.
REQ-026 If START_RECFG and START_READ are high together in IDLE, START_RECFG SHALL win and START_READ SHALL be dropped.
REQ-027 SEQ_BUSY SHALL be high from the cycle after acceptance through the DONE/ERROR cycle.

Reset
REQ-028 On RESETb=0 the block SHALL asynchronously go to IDLE with these output values:
- M_CEb=1, M_WEb=1;
- M_ADDR=0, M_DATA_OUT=0;
- SEQ_BUSY=0, DONE=0, ERROR=0, CUR_CFG=0;
- counters and step index cleared.
REQ-029 Reset mid-sequence SHALL abort with no further bus accesses; a partially written parameter set is not rolled back.

Configuration
REQ-030 With RUPD_SEQ_VERIFY_EN defined, the recfg sequence SHALL insert a verify step between step2 and step3:
- read param 4 and poll;
- compare M_DATA_IN[6:0] to the latched PGM;
- mismatch -> set ERROR, return to IDLE, no reconfigure.
REQ-031 Without RUPD_SEQ_VERIFY_EN, there SHALL be no verify step and no verify logic.

Verification
REQ-032 START_RECFG, PGM=7'h30, status model clears in 3 cycles -> writes observed in order:
- addr0 0x00000004, addr1 0x02;
- addr0 0x00040030, addr1 0x02;
- addr0 0x00050001, addr1 0x02;
- addr0 0x00050001, addr1 0x80;
- then DONE pulse, ERROR=0.
REQ-033 START_READ with status model returning data 0x001 -> addr0 0x00050000, addr1 0x01, then CUR_CFG=0x001 and DONE pulse.
REQ-034 Busy stuck at 1, TIMEOUT_CYC=16 -> ERROR=1 after step0 poll; no write to addr1 with 0x80; SEQ_BUSY=0.
REQ-035 START_READ pulsed during recfg, then both STARTs pulsed in the same IDLE cycle -> first pulse ignored; recfg sequence runs.
REQ-036 RESETb asserted during step1 SETTLE -> outputs at reset values within 0 CLK cycles; no further accesses.
REQ-037 With RUPD_SEQ_VERIFY_EN defined, readback 0x031 for PGM=0x30 -> ERROR=1, no 0x80 write.
